// File: rtl/audio_pkg.sv
// audio_pkg: shared widths, FSM encoding and arbitration modes for the audio frame arbiter.
package audio_pkg;
    localparam int SAMPLE_W = 32;
    localparam int FRAME_DIV_DEFAULT = 251;
    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;
    localparam logic ARB_PRIO = 1'b0;
    localparam logic ARB_RR = 1'b1;
endpackage

// File: rtl/audio_src_buffer.sv
// audio_src_buffer: one-entry valid/ready holding register, emptied by the arbiter's clear.
module audio_src_buffer
    import audio_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                valid_i,
    input  logic [SAMPLE_W-1:0] data_i,
    input  logic                clear_i,
    output logic                ready_o,
    output logic                full_o,
    output logic [SAMPLE_W-1:0] data_o
);
    logic                full_q, full_d, take;
    logic [SAMPLE_W-1:0] data_q, data_d;

    always_comb begin
        take   = valid_i && !full_q;
        full_d = clear_i ? 1'b0 : (take || full_q);
        data_d = take ? data_i : data_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign ready_o = ~full_q;
    assign full_o  = full_q;
    assign data_o  = data_q;
endmodule

// File: rtl/audio_frame_arbiter.sv
// audio_frame_arbiter: frame scheduler granting one of two buffered sources per frame
// to the serializer, with fixed-priority or round-robin arbitration and underrun counting.
module audio_frame_arbiter
    import audio_pkg::*;
#(
    parameter int FRAME_DIV = FRAME_DIV_DEFAULT,
    parameter int HOLD_LAST = 1,
    parameter int CNT_W     = 16
) (
    input  logic                clock_12Mhz,
    input  logic                reset_n,
    input  logic                enable,
    input  logic                arb_mode,
    input  logic [SAMPLE_W-1:0] src0_data,
    input  logic                src0_valid,
    output logic                src0_ready,
    input  logic [SAMPLE_W-1:0] src1_data,
    input  logic                src1_valid,
    output logic                src1_ready,
    output logic [SAMPLE_W-1:0] audio_data_out,
    output logic                frame_strobe,
    output logic                grant_src,
    output logic                underrun,
    output logic [CNT_W-1:0]    underrun_cnt
);
    localparam int CW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [CW-1:0] TC = CW'(FRAME_DIV - 1);

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                rr_q, rr_d, grant_q, grant_d;
    logic                strobe_q, strobe_d, under_q, under_d;
    logic [SAMPLE_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]    ucnt_q, ucnt_d;
    logic                full0, full1, clr0, clr1;
    logic                run, tc, both, pick1, hit, miss;
    logic [SAMPLE_W-1:0] bdata0, bdata1;

    audio_src_buffer u_buf0 (
        .clk_i   (clock_12Mhz),
        .rst_ni  (reset_n),
        .valid_i (src0_valid),
        .data_i  (src0_data),
        .clear_i (clr0),
        .ready_o (src0_ready),
        .full_o  (full0),
        .data_o  (bdata0)
    );

    audio_src_buffer u_buf1 (
        .clk_i   (clock_12Mhz),
        .rst_ni  (reset_n),
        .valid_i (src1_valid),
        .data_i  (src1_data),
        .clear_i (clr1),
        .ready_o (src1_ready),
        .full_o  (full1),
        .data_o  (bdata1)
    );

    // rr_q remembers the last round-robin winner; the other source goes next on contention.
    always_comb begin
        run      = state_q == ST_RUN;
        tc       = run && cnt_q == TC;
        both     = full0 && full1;
        pick1    = both ? (arb_mode == ARB_RR && !rr_q) : full1;
        hit      = tc && (full0 || full1);
        miss     = tc && !hit;
        clr0     = hit && !pick1;
        clr1     = hit && pick1;
        state_d  = enable ? ST_RUN : ST_IDLE;
        cnt_d    = (run && enable && !tc) ? cnt_q + 1'b1 : '0;
        rr_d     = (hit && both && arb_mode == ARB_RR) ? pick1 : rr_q;
        data_d   = hit ? (pick1 ? bdata1 : bdata0) : (miss && HOLD_LAST == 0) ? '0 : data_q;
        grant_d  = hit ? pick1 : grant_q;
        strobe_d = tc;
        under_d  = miss;
        ucnt_d   = (miss && ucnt_q != '1) ? ucnt_q + 1'b1 : ucnt_q;
    end

    always_ff @(posedge clock_12Mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            rr_q     <= 1'b1;
            grant_q  <= 1'b0;
            strobe_q <= 1'b0;
            under_q  <= 1'b0;
            data_q   <= '0;
            ucnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rr_q     <= rr_d;
            grant_q  <= grant_d;
            strobe_q <= strobe_d;
            under_q  <= under_d;
            data_q   <= data_d;
            ucnt_q   <= ucnt_d;
        end
    end

    assign audio_data_out = data_q;
    assign frame_strobe   = strobe_q;
    assign grant_src      = grant_q;
    assign underrun       = under_q;
    assign underrun_cnt   = ucnt_q;
endmodule

// File: tb/tb_audio_frame_arbiter.sv
// tb_audio_frame_arbiter: directed vectors against two arbiters (HOLD_LAST=1 and HOLD_LAST=0) sharing stimulus.
module tb_audio_frame_arbiter;
    logic        clk = 1'b0;
    logic        reset_n, enable, arb_mode;
    logic [31:0] src0_data, src1_data;
    logic        src0_valid, src1_valid;
    logic        a_r0, a_r1, a_stb, a_gnt, a_und;
    logic [31:0] a_dat;
    logic [15:0] a_cnt;
    logic        b_r0, b_r1, b_stb, b_gnt, b_und;
    logic [31:0] b_dat;
    logic [15:0] b_cnt;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    audio_frame_arbiter #(.FRAME_DIV(251), .HOLD_LAST(1), .CNT_W(16)) dut (
        .clock_12Mhz(clk), .reset_n(reset_n), .enable(enable), .arb_mode(arb_mode),
        .src0_data(src0_data), .src0_valid(src0_valid), .src0_ready(a_r0),
        .src1_data(src1_data), .src1_valid(src1_valid), .src1_ready(a_r1),
        .audio_data_out(a_dat), .frame_strobe(a_stb), .grant_src(a_gnt),
        .underrun(a_und), .underrun_cnt(a_cnt)
    );

    audio_frame_arbiter #(.FRAME_DIV(251), .HOLD_LAST(0), .CNT_W(16)) dut_zero (
        .clock_12Mhz(clk), .reset_n(reset_n), .enable(enable), .arb_mode(arb_mode),
        .src0_data(src0_data), .src0_valid(src0_valid), .src0_ready(b_r0),
        .src1_data(src1_data), .src1_valid(src1_valid), .src1_ready(b_r1),
        .audio_data_out(b_dat), .frame_strobe(b_stb), .grant_src(b_gnt),
        .underrun(b_und), .underrun_cnt(b_cnt)
    );

    typedef struct {
        logic        v0;
        logic [31:0] d0;
        logic        v1;
        logic [31:0] d1;
        logic        mode;
        logic [31:0] exp_hold;
        logic [31:0] exp_zero;
        logic        exp_grant;
        logic        exp_under;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic v0, input logic [31:0] d0, input logic v1, input logic [31:0] d1);
        src0_valid = v0;
        src0_data  = d0;
        src1_valid = v1;
        src1_data  = d1;
        tick();
        src0_valid = 1'b0;
        src1_valid = 1'b0;
    endtask

    task automatic wait_strobe(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!a_stb && n < 600);
    endtask

    initial begin
        int n, seen;
        tbl[0] = '{1'b1, 32'h1, 1'b1, 32'h2, 1'b0, 32'h1, 32'h1, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 32'h1, 1'b1, 32'h2, 1'b0, 32'h1, 32'h1, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 32'h1, 1'b1, 32'h2, 1'b1, 32'h1, 32'h1, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 32'h1, 1'b1, 32'h2, 1'b1, 32'h2, 32'h2, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 32'h1, 1'b1, 32'h2, 1'b1, 32'h1, 32'h1, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 32'h1, 1'b1, 32'h2, 1'b1, 32'h2, 32'h2, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h1, 32'h1, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 32'h0, 1'b1, 32'h12345678, 1'b0, 32'h12345678, 32'h12345678, 1'b1, 1'b0};
        tbl[8] = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h12345678, 32'h0, 1'b1, 1'b1};

        reset_n = 1'b0;
        enable = 1'b0;
        arb_mode = 1'b0;
        src0_data = '0;
        src1_data = '0;
        src0_valid = 1'b0;
        src1_valid = 1'b0;
        #12;
        chk("reset data", a_dat, 32'h0);
        chk("reset strobe", {a_stb, a_und, a_gnt}, 3'b000);
        chk("reset cnt", a_cnt, 16'h0);
        reset_n = 1'b1;
        tick();
        chk("ready after reset", {a_r0, a_r1}, 2'b11);

        // Idle sources: three underrun frames of period 251
        enable = 1'b1;
        tick();
        wait_strobe(n);
        chk("first strobe latency", n, 251);
        chk("underrun frame1", {a_und, b_und, b_stb}, 3'b111);
        chk("data frame1", a_dat, 32'h0);
        chk("cnt frame1", a_cnt, 16'd1);
        tick();
        chk("strobe one cycle", {a_stb, a_und}, 2'b00);
        wait_strobe(n);
        chk("period frame2", n + 1, 251);
        wait_strobe(n);
        chk("period frame3", n, 251);
        chk("cnt frame3", a_cnt, 16'd3);
        chk("data frame3", a_dat, 32'h0);

        // Single src0 sample
        chk("src0 ready before", a_r0, 1'b1);
        push(1'b1, 32'hAAAA5555, 1'b0, 32'h0);
        chk("src0 ready after xfer", {a_r0, a_r1}, 2'b01);
        wait_strobe(n);
        chk("src0 strobe period", n + 1, 251);
        chk("src0 data", a_dat, 32'hAAAA5555);
        chk("src0 grant", a_gnt, 1'b0);
        chk("src0 no underrun", a_und, 1'b0);
        chk("src0 ready after commit", a_r0, 1'b1);

        for (int i = 0; i < 9; i++) begin
            arb_mode = tbl[i].mode;
            push(tbl[i].v0, tbl[i].d0, tbl[i].v1, tbl[i].d1);
            wait_strobe(n);
            chk($sformatf("vec%0d period", i), n + 1, 251);
            chk($sformatf("vec%0d data hold", i), a_dat, tbl[i].exp_hold);
            chk($sformatf("vec%0d data zero", i), b_dat, tbl[i].exp_zero);
            chk($sformatf("vec%0d grant", i), {a_gnt, b_gnt}, {2{tbl[i].exp_grant}});
            chk($sformatf("vec%0d underrun", i), {a_und, b_und}, {2{tbl[i].exp_under}});
        end
        chk("cnt after table", a_cnt, 16'd4);

        // Drop enable mid-frame at counter 100
        repeat (100) tick();
        enable = 1'b0;
        seen = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (a_stb) seen++;
        end
        chk("no strobe while idle", seen, 0);
        enable = 1'b1;
        tick();
        wait_strobe(n);
        chk("re-enable latency", n, 251);
        chk("re-enable hold data", a_dat, 32'h12345678);
        chk("re-enable zero data", b_dat, 32'h0);
        chk("re-enable cnt", a_cnt, 16'd5);

        // Reset mid-frame with src1 buffered
        push(1'b0, 32'h0, 1'b1, 32'hDEADBEEF);
        chk("src1 buffered", a_r1, 1'b0);
        repeat (50) tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk("async reset data", a_dat, 32'h0);
        chk("async reset flags", {a_stb, a_und, a_gnt}, 3'b000);
        chk("async reset cnt", a_cnt, 16'h0);
        chk("async reset ready", {a_r0, a_r1}, 2'b11);
        #1;
        reset_n = 1'b1;
        tick();
        wait_strobe(n);
        chk("post-reset latency", n, 251);
        chk("post-reset data", a_dat, 32'h0);
        chk("post-reset underrun", a_und, 1'b1);
        chk("post-reset cnt", a_cnt, 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
